ucode_sequencer: RTL

Microcode sequencer for the CPU core: requests instruction bytes from the memory interface, drives the 9-bit address into the microcode ROM, and steps through micro-op words using sequencing bits returned in the ROM's control word. It also handles end-of-instruction, continuation chaining, HALT, and optional interrupt dispatch. It sits between the bus/fetch unit and the microcode ROM; the datapath consumes the ROM output qualified by `ucode_valid`.

---
 rtl/ucode_pkg.sv | 27 ++
 rtl/ucode_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ucode_pkg.sv
// Shared constants for the microcode sequencer: address width, chain/IRQ entries,
// FSM state encodings and the control-word bit layout returned by the ROM.
package ucode_pkg;

  localparam int UCODE_ADDR_W = 9;

  localparam logic [UCODE_ADDR_W-1:0] CHAIN_BASE  = 9'h100;
  localparam int                      CHAIN_COUNT = 24;
  localparam logic [UCODE_ADDR_W-1:0] IRQ_ENTRY   = 9'h118;

  typedef logic [2:0] state_t;

  localparam state_t S_RESET = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_EXEC  = 3'd2;
  localparam state_t S_HALT  = 3'd3;
  localparam state_t S_IRQ   = 3'd4;

  // Sequencing field of the ROM control word: three flags, then the chain index.
  localparam int CW_END_BIT   = 0;
  localparam int CW_HALT_BIT  = 1;
  localparam int CW_CHAIN_BIT = 2;
  localparam int CW_SEL_LSB   = 3;
  localparam int CW_SEL_W     = 5;
  localparam int CW_W         = CW_SEL_LSB + CW_SEL_W;

endpackage

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: opcode fetch, ROM address stepping, chaining, HALT and
// interrupt dispatch. Interrupt dispatch exists only when UCODE_IRQ_EN is defined.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int                ADDR_W      = UCODE_ADDR_W,
  parameter logic [ADDR_W-1:0] CHAIN_BASE  = ucode_pkg::CHAIN_BASE,
  parameter int                CHAIN_COUNT = ucode_pkg::CHAIN_COUNT,
  parameter logic [ADDR_W-1:0] IRQ_ENTRY   = ucode_pkg::IRQ_ENTRY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic              fetch_req,
  input  logic              fetch_valid,
  input  logic [7:0]        fetch_data,
  input  logic              ctrl_end,
  input  logic              ctrl_halt,
  input  logic              ctrl_chain,
  input  logic [4:0]        ctrl_chain_sel,
  input  logic              irq_pending,
  input  logic              ime,
  output logic [ADDR_W-1:0] ucode_addr,
  output logic              ucode_valid,
  output logic [7:0]        ir,
  output logic              irq_ack,
  output logic              halted,
  output logic              ucode_err,
  output logic [2:0]        dbg_state_o
);

  // Handshake: fetch_data is consumed only in a cycle where fetch_req is high and
  // fetch_valid is high; fetch_valid in any other cycle is ignored.

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              fetch_req_q, fetch_req_d;
  logic [7:0]        ir_q, ir_d;
  logic              irq_ack_q, irq_ack_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  logic [CW_W-1:0]     cw;
  logic                cw_end, cw_halt, cw_chain, cw_multi, sel_oob;
  logic [CW_SEL_W-1:0] cw_sel;
  logic                go_end, go_fetch, go_irq;

  always_comb begin
    cw                                = '0;
    cw[CW_END_BIT]                    = ctrl_end;
    cw[CW_HALT_BIT]                   = ctrl_halt;
    cw[CW_CHAIN_BIT]                  = ctrl_chain;
    cw[CW_SEL_LSB +: CW_SEL_W]        = ctrl_chain_sel;
  end

  assign cw_end   = cw[CW_END_BIT];
  assign cw_halt  = cw[CW_HALT_BIT];
  assign cw_chain = cw[CW_CHAIN_BIT];
  assign cw_sel   = cw[CW_SEL_LSB +: CW_SEL_W];
  assign cw_multi = (cw_end & cw_halt) | (cw_end & cw_chain) | (cw_halt & cw_chain);
  assign sel_oob  = int'(cw_sel) >= CHAIN_COUNT;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    fetch_req_d = fetch_req_q;
    ir_d        = ir_q;
    irq_ack_d   = 1'b0;
    halted_d    = halted_q;
    err_d       = err_q;
    go_end      = 1'b0;
    go_fetch    = 1'b0;
    go_irq      = 1'b0;

    case (state_q)
      S_RESET: go_fetch = 1'b1;
      S_FETCH: begin
        if (fetch_valid) begin
          ir_d        = fetch_data;
          addr_d      = {{(ADDR_W-8){1'b0}}, fetch_data};
          valid_d     = 1'b1;
          fetch_req_d = 1'b0;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (cw_multi) err_d = 1'b1;
          if (cw_end) begin
            go_end = 1'b1;
          end else if (cw_halt) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            valid_d  = 1'b0;
          end else if (cw_chain) begin
            if (sel_oob) begin
              err_d    = 1'b1;
              go_fetch = 1'b1;
            end else begin
              addr_d = CHAIN_BASE + ADDR_W'(cw_sel);
            end
          end else begin
            // A word with no sequencing bit is malformed; finish the instruction.
            err_d  = 1'b1;
            go_end = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (irq_pending) begin
          halted_d = 1'b0;
`ifdef UCODE_IRQ_EN
          if (ime) go_irq = 1'b1;
          else     go_fetch = 1'b1;
`else
          go_fetch = 1'b1;
`endif
        end
      end
`ifdef UCODE_IRQ_EN
      S_IRQ: begin
        state_d = S_EXEC;
        valid_d = 1'b1;
      end
`endif
      default: go_fetch = 1'b1;
    endcase

    if (go_end) begin
`ifdef UCODE_IRQ_EN
      if (irq_pending && ime) go_irq = 1'b1;
      else                    go_fetch = 1'b1;
`else
      go_fetch = 1'b1;
`endif
    end

    if (go_fetch) begin
      state_d     = S_FETCH;
      valid_d     = 1'b0;
      fetch_req_d = 1'b1;
    end

`ifdef UCODE_IRQ_EN
    if (go_irq) begin
      state_d     = S_IRQ;
      irq_ack_d   = 1'b1;
      addr_d      = IRQ_ENTRY;
      valid_d     = 1'b0;
      fetch_req_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      fetch_req_q <= 1'b0;
      ir_q        <= '0;
      irq_ack_q   <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      fetch_req_q <= fetch_req_d;
      ir_q        <= ir_d;
      irq_ack_q   <= irq_ack_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

`ifdef UCODE_IRQ_EN
  assign irq_ack = irq_ack_q;
`else
  logic unused_irq;
  assign unused_irq = ime ^ irq_ack_q ^ go_irq;
  assign irq_ack    = 1'b0;
`endif

  assign fetch_req   = fetch_req_q;
  assign ucode_addr  = addr_q;
  assign ucode_valid = valid_q;
  assign ir          = ir_q;
  assign halted      = halted_q;
  assign ucode_err   = err_q;
  assign dbg_state_o = state_q;

endmodule
